// File: rtl/video_pkg.sv
// Shared definitions for the video block: PPU mode encodings, STAT enable layout
// and default LCD timing constants.
package video_pkg;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_DRAW   = 2'd3
  } ppu_mode_t;

  // Field order mirrors STAT bits 6..3 so the struct maps straight onto the data bus.
  typedef struct packed {
    logic lyc;
    logic oam;
    logic vbl;
    logic hbl;
  } stat_en_t;

  localparam int DEF_DOTS_PER_LINE   = 456;
  localparam int DEF_LINES_PER_FRAME = 154;
  localparam int DEF_VISIBLE_LINES   = 144;
  localparam int DEF_OAM_DOTS        = 80;
  localparam int DEF_MODE3_MIN       = 172;
  localparam int DEF_MODE3_MAX       = 289;

endpackage

// File: rtl/lcd_line_timing_stat_irq.sv
// STAT interrupt source: ORs the enabled conditions into one line and emits a
// single-cycle request on each rising edge of that line.
module stat_irq_edge
  import video_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  stat_en_t  enables,
  input  ppu_mode_t mode,
  input  logic      coincidence,
  input  logic      lcd_en,
  output logic      int_stat
);

  logic stat_line;
  logic stat_line_q;

  // HBLANK is also the reported mode while the LCD is off, so that source is gated.
  assign stat_line = (enables.lyc & coincidence)
                   | (enables.oam & (mode == MODE_OAM))
                   | (enables.vbl & (mode == MODE_VBLANK))
                   | (enables.hbl & (mode == MODE_HBLANK) & lcd_en);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_line_q <= 1'b0;
      int_stat    <= 1'b0;
    end else begin
      stat_line_q <= stat_line;
      int_stat    <= stat_line & ~stat_line_q;
    end
  end

endmodule

// File: rtl/lcd_line_timing.sv
// Dot-rate LCD timing generator: dot/line counters, PPU mode sequencing, LY/LYC
// compare, VBLANK/STAT interrupt requests and the STAT (FF41) register.
module lcd_line_timing
  import video_pkg::*;
#(
  parameter int DOTS_PER_LINE   = DEF_DOTS_PER_LINE,
  parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
  parameter int VISIBLE_LINES   = DEF_VISIBLE_LINES,
  parameter int OAM_DOTS        = DEF_OAM_DOTS,
  parameter int MODE3_MIN       = DEF_MODE3_MIN,
  parameter int MODE3_MAX       = DEF_MODE3_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_en,
  input  logic [7:0] lyc,
  input  logic       mode3_done,
  input  logic       cpu_rd2,
  input  logic       cpu_wr2,
  input  logic       ff41,
  inout  tri   [7:0] d,
  output logic [7:0] ly,
  output logic [1:0] mode,
  output logic       coincidence,
  output logic       line_start,
  output logic       int_vblank,
  output logic       int_stat
);

  localparam logic [8:0] LAST_DOT     = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] OAM_END      = 9'(OAM_DOTS);
  localparam logic [8:0] OAM_LAST     = 9'(OAM_DOTS - 1);
  localparam logic [8:0] M3_MIN_DOT   = 9'(OAM_DOTS + MODE3_MIN);
  localparam logic [8:0] M3_LAST_DOT  = 9'(OAM_DOTS + MODE3_MAX - 1);
  localparam logic [7:0] LAST_LINE    = 8'(LINES_PER_FRAME - 1);
  localparam logic [7:0] VBL_LINE     = 8'(VISIBLE_LINES);
  localparam logic [7:0] PRE_VBL_LINE = 8'(VISIBLE_LINES - 1);

  logic [8:0] dot, dot_nxt;
  logic [7:0] ly_nxt;
  logic       in_m3, in_m3_nxt;
  logic       end_of_line;
  logic       stat_rd, stat_wr;
  stat_en_t   enables;
  ppu_mode_t  mode_e;

  assign end_of_line = (dot == LAST_DOT);
  assign stat_rd     = cpu_rd2 & ff41;
  assign stat_wr     = cpu_wr2 & ff41;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dot   <= '0;
      ly    <= '0;
      in_m3 <= 1'b0;
    end else begin
      dot   <= dot_nxt;
      ly    <= ly_nxt;
      in_m3 <= in_m3_nxt;
    end
  end

  // With the LCD off everything collapses to line 0 dot 0 so re-enable starts a fresh frame.
  always_comb begin
    dot_nxt   = '0;
    ly_nxt    = '0;
    in_m3_nxt = 1'b0;
    if (lcd_en) begin
      dot_nxt   = end_of_line ? '0 : dot + 9'd1;
      ly_nxt    = ly;
      in_m3_nxt = in_m3;
      if (end_of_line)
        ly_nxt = (ly == LAST_LINE) ? '0 : ly + 8'd1;
      if ((dot == OAM_LAST) && (ly < VBL_LINE))
        in_m3_nxt = 1'b1;
      else if (in_m3 && ((mode3_done && (dot >= M3_MIN_DOT)) || (dot == M3_LAST_DOT)))
        in_m3_nxt = 1'b0;
    end
  end

  always_comb begin
    if (!lcd_en)
      mode_e = MODE_HBLANK;
    else if (ly >= VBL_LINE)
      mode_e = MODE_VBLANK;
    else if (dot < OAM_END)
      mode_e = MODE_OAM;
    else if (in_m3)
      mode_e = MODE_DRAW;
    else
      mode_e = MODE_HBLANK;
  end

  assign mode = mode_e;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coincidence <= 1'b0;
      line_start  <= 1'b0;
      int_vblank  <= 1'b0;
      enables     <= '0;
    end else begin
      coincidence <= (ly == lyc);
      line_start  <= lcd_en & end_of_line;
      int_vblank  <= lcd_en & end_of_line & (ly == PRE_VBL_LINE);
      if (stat_wr)
        enables <= d[6:3];
    end
  end

  assign d = stat_rd ? {1'b1, enables, coincidence, mode} : 8'hzz;

  stat_irq_edge u_stat_irq (
    .clk         (clk),
    .reset       (reset),
    .enables     (enables),
    .mode        (mode_e),
    .coincidence (coincidence),
    .lcd_en      (lcd_en),
    .int_stat    (int_stat)
  );

endmodule

// File: tb/tb_lcd_line_timing.sv
// Self-checking bench for lcd_line_timing: directed frame walk with randomized
// middle section, compared against a cycle-count based reference model.
module tb_lcd_line_timing;

  localparam int DPL  = 456;
  localparam int LPF  = 154;
  localparam int VIS  = 144;
  localparam int OAM  = 80;
  localparam int M3MN = 172;
  localparam int M3MX = 289;

  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_en;
  logic [7:0] lyc;
  logic       mode3_done;
  logic       cpu_rd2, cpu_wr2, ff41;
  logic [7:0] d_drv;
  logic       d_oe;
  tri   [7:0] d;
  logic [7:0] ly;
  logic [1:0] mode;
  logic       coincidence, line_start, int_vblank, int_stat;

  assign d = d_oe ? d_drv : 8'hzz;

  always #5 clk = ~clk;

  lcd_line_timing dut (
    .clk         (clk),
    .reset       (reset),
    .lcd_en      (lcd_en),
    .lyc         (lyc),
    .mode3_done  (mode3_done),
    .cpu_rd2     (cpu_rd2),
    .cpu_wr2     (cpu_wr2),
    .ff41        (ff41),
    .d           (d),
    .ly          (ly),
    .mode        (mode),
    .coincidence (coincidence),
    .line_start  (line_start),
    .int_vblank  (int_vblank),
    .int_stat    (int_stat)
  );

  // Reference model: position is derived from the count of enabled cycles.
  int         t, m3_end, cycle;
  logic [3:0] m_en;
  logic       m_coin, m_ls, m_vbl, m_int, m_slq;
  int         vectors, miscompares, stat_pulses, vbl_pulses;

  function automatic int m_dot();
    return t % DPL;
  endfunction

  function automatic int m_line();
    return (t / DPL) % LPF;
  endfunction

  function automatic logic [1:0] m_mode();
    if (!lcd_en) return 2'd0;
    if (m_line() >= VIS) return 2'd1;
    if (m_dot() < OAM) return 2'd2;
    if (m_dot() < m3_end) return 2'd3;
    return 2'd0;
  endfunction

  task automatic model_reset();
    t = 0; m3_end = OAM + M3MX; cycle = 0;
    m_en = '0; m_coin = 0; m_ls = 0; m_vbl = 0; m_int = 0; m_slq = 0;
    stat_pulses = 0; vbl_pulses = 0;
  endtask

  task automatic model_edge();
    int         pd, pl;
    logic [1:0] pm;
    logic       sl;
    pd = m_dot();
    pl = m_line();
    pm = m_mode();
    sl = (m_en[3] & m_coin) | (m_en[2] & (pm == 2'd2)) | (m_en[1] & (pm == 2'd1))
       | (m_en[0] & (pm == 2'd0) & lcd_en);
    if (lcd_en && pm == 2'd3 && mode3_done && pd >= OAM + M3MN) m3_end = pd + 1;
    m_int = sl & ~m_slq;
    m_slq = sl;
    m_coin = (pl == int'(lyc));
    m_ls  = lcd_en && (pd == DPL - 1);
    m_vbl = lcd_en && (pd == DPL - 1) && (pl == VIS - 1);
    if (cpu_wr2 && ff41) m_en = d_drv[6:3];
    t = lcd_en ? t + 1 : 0;
    if (m_dot() == 0) m3_end = OAM + M3MX;
  endtask

  task automatic check_output();
    logic [13:0] exp_v, got_v;
    logic [7:0]  exp_d;
    exp_v = {8'(m_line()), m_mode(), m_coin, m_ls, m_vbl, m_int};
    got_v = {ly, mode, coincidence, line_start, int_vblank, int_stat};
    vectors++;
    assert (got_v === exp_v) else begin
      miscompares++;
      $error("[TB] FAIL state cyc=%0d got=%h exp=%h", cycle, got_v, exp_v);
    end
    if (cpu_rd2 && ff41 && !cpu_wr2) begin
      exp_d = {1'b1, m_en, m_coin, m_mode()};
      vectors++;
      assert (d === exp_d) else begin
        miscompares++;
        $error("[TB] FAIL stat_read cyc=%0d got=%h exp=%h", cycle, d, exp_d);
      end
    end
  endtask

  task automatic expect_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s cyc=%0d got=%h exp=%h", tag, cycle, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cycle++;
    @(negedge clk);
    if (int_stat === 1'b1) stat_pulses++;
    if (int_vblank === 1'b1) vbl_pulses++;
    check_output();
  endtask

  task automatic run_to(input int target);
    while (cycle < target) tick();
  endtask

  task automatic apply_stimulus(input logic rd, input logic wr, input logic sel, input logic [7:0] v);
    cpu_rd2 = rd; cpu_wr2 = wr; ff41 = sel; d_oe = wr; d_drv = v;
  endtask

  task automatic write_stat(input logic [7:0] v);
    apply_stimulus(1'b0, 1'b1, 1'b1, v);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic read_stat(input string tag, input logic [7:0] exp);
    apply_stimulus(1'b1, 1'b0, 1'b1, 8'h00);
    tick();
    expect_eq(tag, 16'(d), 16'(exp));
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int base;
    vectors = 0; miscompares = 0;
    reset = 1'b1; lcd_en = 1'b0; lyc = 8'd5; mode3_done = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    model_reset();
    repeat (2) @(negedge clk);
    expect_eq("reset_state", 16'({ly, mode, coincidence, line_start, int_vblank, int_stat}), 16'h0000);

    // Release with the LCD on; walk line 0 with mode3_done held low.
    reset = 1'b0; lcd_en = 1'b1;
    model_reset();
    #1;
    check_output();
    expect_eq("mode_dot0", 16'(mode), 16'd2);
    run_to(79);  expect_eq("mode_dot79", 16'(mode), 16'd2);
    run_to(80);  expect_eq("mode_dot80", 16'(mode), 16'd3);
    run_to(368); expect_eq("mode_dot368", 16'(mode), 16'd3);
    run_to(369); expect_eq("mode_dot369", 16'(mode), 16'd0);
    run_to(455); expect_eq("no_line_start", 16'(line_start), 16'd0);
    run_to(456); expect_eq("line_start_1", 16'({line_start, ly}), 16'h101);

    // Line 1: an early mode3_done is ignored, a late one ends drawing.
    run_to(DPL + 180); mode3_done = 1'b1; tick(); mode3_done = 1'b0;
    expect_eq("m3_early_ignored", 16'(mode), 16'd3);
    run_to(DPL + 280); expect_eq("m3_before_done", 16'(mode), 16'd3);
    mode3_done = 1'b1; tick(); mode3_done = 1'b0;
    expect_eq("m3_done_dot281", 16'(mode), 16'd0);
    run_to(2 * DPL); expect_eq("line_start_2", 16'(line_start), 16'd1);

    // LYC=5 with en_lyc; then add en_hbl without causing another pulse.
    run_to(3 * DPL + 20); write_stat(8'h40);
    run_to(5 * DPL);
    expect_eq("coin_ly5_dot0", 16'(coincidence), 16'd0);
    stat_pulses = 0;
    run_to(5 * DPL + 1); expect_eq("coin_ly5_dot1", 16'(coincidence), 16'd1);
    run_to(5 * DPL + 2); expect_eq("lyc_int", 16'(int_stat), 16'd1);
    run_to(5 * DPL + 10); write_stat(8'h48);
    run_to(6 * DPL); expect_eq("lyc_single_pulse", 16'(stat_pulses), 16'd1);

    // Randomized middle of the frame: mode3_done, STAT reads/writes, LYC changes.
    while (cycle < 140 * DPL) begin
      int r;
      r = $urandom_range(0, 15);
      mode3_done = ($urandom_range(0, 31) == 0);
      if (r == 0)      apply_stimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
      else if (r < 4)  apply_stimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'h00);
      else             apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
      if ($urandom_range(0, 2047) == 0) lyc = 8'($urandom_range(0, 153));
      tick();
    end
    mode3_done = 1'b0; lyc = 8'd5;
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);

    // VBLANK entry at cycle 144*456.
    run_to(VIS * DPL - 1); expect_eq("pre_vblank", 16'({ly, int_vblank}), 16'({8'd143, 1'b0}));
    run_to(VIS * DPL);     expect_eq("vblank_pulse", 16'({ly, mode, int_vblank}), 16'({8'd144, 2'd1, 1'b1}));
    tick();                expect_eq("vblank_one_cycle", 16'(int_vblank), 16'd0);

    // STAT register readback during vblank.
    run_to(145 * DPL + 30); write_stat(8'hFF);
    read_stat("stat_rd_nocoin", 8'hF9);
    lyc = 8'd150;
    run_to(150 * DPL + 5);
    read_stat("stat_rd_coin", 8'hFD);
    lyc = 8'd5;

    // Frame wrap at cycle 154*456.
    run_to(LPF * DPL - 1); expect_eq("ly_153", 16'(ly), 16'd153);
    run_to(LPF * DPL);     expect_eq("ly_wrap", 16'({ly, mode, line_start}), 16'({8'd0, 2'd2, 1'b1}));
    expect_eq("vblank_count", 16'(vbl_pulses), 16'd1);

    // LCD off mid-line 50 for 1000 cycles, then re-enable.
    base = LPF * DPL;
    run_to(base + 50 * DPL + 200);
    expect_eq("ly_50", 16'(ly), 16'd50);
    lcd_en = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      expect_eq("lcd_off", 16'({ly, mode, int_stat, int_vblank, line_start}), 16'h0000);
    end
    lcd_en = 1'b1;
    #1;
    expect_eq("reenable_mode", 16'({ly, mode}), 16'({8'd0, 2'd2}));
    for (int i = 0; i < 500; i++) tick();

    // Asynchronous reset mid-line; no interrupt may follow the release.
    #2 reset = 1'b1;
    #1;
    expect_eq("async_reset", 16'({ly, mode, coincidence, line_start, int_vblank, int_stat}),
              16'({8'd0, 2'd2, 4'd0}));
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_output();
    for (int i = 0; i < 20; i++) tick();
    expect_eq("no_int_after_reset", 16'(stat_pulses), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
